// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that shares one memory port among NUM_MASTERS request/ack clients.
// Latency: request seen in IDLE -> strobe for WAIT_STATES+1 cycles -> one-cycle ACK -> one IDLE gap.
// Backpressure: a master holds M_REQ until its ACK; losers simply wait, no request is ever dropped.
module mem_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 26,
  parameter int WAIT_STATES = 1
) (
  input  logic                                                  CLK,
  input  logic                                                  RST,
  input  logic [NUM_MASTERS-1:0]                                M_REQ,
  input  logic [NUM_MASTERS-1:0]                                M_WE,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]                     M_ADDR,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]                     M_WDATA,
  output logic [NUM_MASTERS-1:0]                                M_ACK,
  output logic [DATA_WIDTH-1:0]                                 M_RDATA,
  output logic [((NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1)-1:0] GRANT_ID,
  output logic [ADDR_WIDTH-1:0]                                 MEM_ADDR,
  output logic [DATA_WIDTH-1:0]                                 MEM_DATA_IN,
  input  logic [DATA_WIDTH-1:0]                                 MEM_DATA_OUT,
  output logic                                                  MEM_READ,
  output logic                                                  MEM_WRITE
);

  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    cnt;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] winner;
  logic          found;
  int            arb_idx;

  // Round-robin search starting just after the last master served.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    arb_idx = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      arb_idx = (int'(last_grant) + 1 + i) % NUM_MASTERS;
      if (!found && M_REQ[arb_idx]) begin
        found  = 1'b1;
        winner = GW'(arb_idx);
      end
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: grant when anyone asks, hold ACCESS until the wait counter runs out, one DONE cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs: latch the winner's request, drive strobes, capture read data, pulse ACK.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      M_ACK       <= '0;
      M_RDATA     <= '0;
      GRANT_ID    <= '0;
      MEM_ADDR    <= '0;
      MEM_DATA_IN <= '0;
      MEM_READ    <= 1'b0;
      MEM_WRITE   <= 1'b0;
      cnt         <= 4'd0;
      last_grant  <= GW'(NUM_MASTERS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            GRANT_ID    <= winner;
            MEM_ADDR    <= M_ADDR[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
            MEM_DATA_IN <= M_WE[winner] ? M_WDATA[int'(winner)*DATA_WIDTH +: DATA_WIDTH] : '0;
            MEM_READ    <= !M_WE[winner];
            MEM_WRITE   <= M_WE[winner];
            cnt         <= 4'(WAIT_STATES);
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            // Strobe polarity doubles as the latched direction; only reads touch M_RDATA.
            if (MEM_READ) M_RDATA <= MEM_DATA_OUT;
            MEM_READ        <= 1'b0;
            MEM_WRITE       <= 1'b0;
            MEM_DATA_IN     <= '0;
            M_ACK           <= '0;
            M_ACK[GRANT_ID] <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          M_ACK      <= '0;
          last_grant <= GRANT_ID;
        end
        default: begin
          M_ACK <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: three instances with WAIT_STATES 1, 0 and 3 share stimulus.
// Latency: every check is sampled on the falling edge; cycle 0 is the cycle a request is first driven.
// Backpressure: masters hold M_REQ until their ACK is observed, then release it.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_req;
  logic [1:0]  m_we;
  logic [51:0] m_addr;
  logic [63:0] m_wdata;
  logic [31:0] mem_dout;

  logic [1:0]  ack_w1, ack_w0, ack_w3;
  logic [31:0] rdata_w1, rdata_w0, rdata_w3;
  logic [0:0]  gid_w1, gid_w0, gid_w3;
  logic [25:0] addr_w1, addr_w0, addr_w3;
  logic [31:0] din_w1, din_w0, din_w3;
  logic        rd_w1, rd_w0, rd_w3;
  logic        wr_w1, wr_w0, wr_w3;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.NUM_MASTERS(2), .DATA_WIDTH(32), .ADDR_WIDTH(26), .WAIT_STATES(1)) u_dut1 (
    .CLK(clk), .RST(rst), .M_REQ(m_req), .M_WE(m_we), .M_ADDR(m_addr), .M_WDATA(m_wdata),
    .M_ACK(ack_w1), .M_RDATA(rdata_w1), .GRANT_ID(gid_w1), .MEM_ADDR(addr_w1),
    .MEM_DATA_IN(din_w1), .MEM_DATA_OUT(mem_dout), .MEM_READ(rd_w1), .MEM_WRITE(wr_w1));

  mem_bus_arbiter #(.NUM_MASTERS(2), .DATA_WIDTH(32), .ADDR_WIDTH(26), .WAIT_STATES(0)) u_dut0 (
    .CLK(clk), .RST(rst), .M_REQ(m_req), .M_WE(m_we), .M_ADDR(m_addr), .M_WDATA(m_wdata),
    .M_ACK(ack_w0), .M_RDATA(rdata_w0), .GRANT_ID(gid_w0), .MEM_ADDR(addr_w0),
    .MEM_DATA_IN(din_w0), .MEM_DATA_OUT(mem_dout), .MEM_READ(rd_w0), .MEM_WRITE(wr_w0));

  mem_bus_arbiter #(.NUM_MASTERS(2), .DATA_WIDTH(32), .ADDR_WIDTH(26), .WAIT_STATES(3)) u_dut3 (
    .CLK(clk), .RST(rst), .M_REQ(m_req), .M_WE(m_we), .M_ADDR(m_addr), .M_WDATA(m_wdata),
    .M_ACK(ack_w3), .M_RDATA(rdata_w3), .GRANT_ID(gid_w3), .MEM_ADDR(addr_w3),
    .MEM_DATA_IN(din_w3), .MEM_DATA_OUT(mem_dout), .MEM_READ(rd_w3), .MEM_WRITE(wr_w3));

  task automatic do_reset();
    rst   = 1'b1;
    m_req = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_req = 2'b00; m_we = 2'b00; m_addr = '0; m_wdata = '0; mem_dout = '0;
    @(negedge clk);
    checks++; if (ack_w1 !== 2'b00) $display("FAIL reset_ack: got %b want 00", ack_w1); else passes++;
    checks++; if (rdata_w1 !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rdata_w1); else passes++;
    checks++; if (gid_w1 !== 1'b0) $display("FAIL reset_gid: got %b want 0", gid_w1); else passes++;
    checks++; if (addr_w1 !== 26'h0) $display("FAIL reset_addr: got %h want 0", addr_w1); else passes++;
    checks++; if (din_w1 !== 32'h0) $display("FAIL reset_din: got %h want 0", din_w1); else passes++;
    checks++; if ({rd_w1, wr_w1} !== 2'b00) $display("FAIL reset_strobes: got %b want 00", {rd_w1, wr_w1}); else passes++;
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({rd_w1, wr_w1, ack_w1} !== 4'b0000) $display("FAIL idle_no_req: got %b want 0000", {rd_w1, wr_w1, ack_w1}); else passes++;
  endtask

  task automatic test_read();
    logic exp_rd;
    logic [1:0] exp_ack;
    m_we = 2'b00; m_addr[25:0] = 26'h0000010; mem_dout = 32'h12345678; m_req = 2'b01;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      exp_rd  = (c == 1 || c == 2);
      exp_ack = (c == 3) ? 2'b01 : 2'b00;
      checks++; if (rd_w1 !== exp_rd) $display("FAIL read_rd c%0d: got %b want %b", c, rd_w1, exp_rd); else passes++;
      checks++; if (wr_w1 !== 1'b0) $display("FAIL read_wr c%0d: got %b want 0", c, wr_w1); else passes++;
      checks++; if (ack_w1 !== exp_ack) $display("FAIL read_ack c%0d: got %b want %b", c, ack_w1, exp_ack); else passes++;
      if (c <= 2) begin
        checks++; if (addr_w1 !== 26'h0000010) $display("FAIL read_addr c%0d: got %h want 0000010", c, addr_w1); else passes++;
        checks++; if (din_w1 !== 32'h0) $display("FAIL read_din c%0d: got %h want 0", c, din_w1); else passes++;
      end
      if (c >= 3) begin
        checks++; if (rdata_w1 !== 32'h12345678) $display("FAIL read_rdata c%0d: got %h want 12345678", c, rdata_w1); else passes++;
      end
      if (c == 3) begin
        checks++; if (gid_w1 !== 1'b0) $display("FAIL read_gid: got %b want 0", gid_w1); else passes++;
        m_req    = 2'b00;
        mem_dout = 32'hFFFF0000;
      end
    end
  endtask

  task automatic test_write();
    logic exp_wr;
    logic [1:0]  exp_ack;
    logic [31:0] exp_din;
    m_we = 2'b10; m_addr[51:26] = 26'h0000020; m_wdata[63:32] = 32'hDEADBEEF;
    mem_dout = 32'hCAFEF00D; m_req = 2'b10;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      exp_wr  = (c == 1 || c == 2);
      exp_ack = (c == 3) ? 2'b10 : 2'b00;
      exp_din = exp_wr ? 32'hDEADBEEF : 32'h0;
      checks++; if (wr_w1 !== exp_wr) $display("FAIL write_wr c%0d: got %b want %b", c, wr_w1, exp_wr); else passes++;
      checks++; if (rd_w1 !== 1'b0) $display("FAIL write_rd c%0d: got %b want 0", c, rd_w1); else passes++;
      checks++; if (din_w1 !== exp_din) $display("FAIL write_din c%0d: got %h want %h", c, din_w1, exp_din); else passes++;
      checks++; if (ack_w1 !== exp_ack) $display("FAIL write_ack c%0d: got %b want %b", c, ack_w1, exp_ack); else passes++;
      checks++; if (rdata_w1 !== 32'h12345678) $display("FAIL write_rdata_hold c%0d: got %h want 12345678", c, rdata_w1); else passes++;
      if (c <= 2) begin
        checks++; if (addr_w1 !== 26'h0000020) $display("FAIL write_addr c%0d: got %h want 0000020", c, addr_w1); else passes++;
      end
      if (c == 1) begin
        // Master scribbles over its request after grant; the access must not notice.
        m_wdata[63:32] = 32'h0; m_addr[51:26] = 26'h00003FF; m_we = 2'b00;
      end
      if (c == 3) begin
        checks++; if (gid_w1 !== 1'b1) $display("FAIL write_gid: got %b want 1", gid_w1); else passes++;
        m_req = 2'b00;
      end
    end
  endtask

  task automatic test_drop_req();
    logic exp_rd;
    logic [1:0] exp_ack;
    do_reset();
    m_we = 2'b00; m_addr[25:0] = 26'h0000044; mem_dout = 32'hA5A5A5A5; m_req = 2'b01;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      exp_rd  = (c == 1 || c == 2);
      exp_ack = (c == 3) ? 2'b01 : 2'b00;
      checks++; if (rd_w1 !== exp_rd) $display("FAIL drop_rd c%0d: got %b want %b", c, rd_w1, exp_rd); else passes++;
      checks++; if (ack_w1 !== exp_ack) $display("FAIL drop_ack c%0d: got %b want %b", c, ack_w1, exp_ack); else passes++;
      if (c == 1) m_req = 2'b00;
      if (c == 3) begin
        checks++; if (rdata_w1 !== 32'hA5A5A5A5) $display("FAIL drop_rdata: got %h want a5a5a5a5", rdata_w1); else passes++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_rd, exp_wr;
    logic [1:0] exp_ack;
    do_reset();
    m_we = 2'b10; m_addr = {26'h0000022, 26'h0000011}; m_wdata[63:32] = 32'h55AA55AA;
    mem_dout = 32'h0BADF00D; m_req = 2'b11;
    // Each transaction is WAIT_STATES+3 = 4 cycles: two strobe cycles, ACK, one IDLE gap.
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      exp_rd  = ((c % 8) == 1 || (c % 8) == 2);
      exp_wr  = ((c % 8) == 5 || (c % 8) == 6);
      exp_ack = ((c % 4) == 3) ? (((c / 4) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      checks++; if (ack_w1 !== exp_ack) $display("FAIL b2b_ack c%0d: got %b want %b", c, ack_w1, exp_ack); else passes++;
      checks++; if (rd_w1 !== exp_rd) $display("FAIL b2b_rd c%0d: got %b want %b", c, rd_w1, exp_rd); else passes++;
      checks++; if (wr_w1 !== exp_wr) $display("FAIL b2b_wr c%0d: got %b want %b", c, wr_w1, exp_wr); else passes++;
      checks++; if ((rd_w1 & wr_w1) !== 1'b0) $display("FAIL b2b_both_strobes c%0d: got rd=%b wr=%b", c, rd_w1, wr_w1); else passes++;
      checks++; if (!$onehot0(ack_w1)) $display("FAIL b2b_ack_onehot c%0d: got %b", c, ack_w1); else passes++;
      if (exp_wr) begin
        checks++; if (din_w1 !== 32'h55AA55AA) $display("FAIL b2b_din c%0d: got %h want 55aa55aa", c, din_w1); else passes++;
      end
      if (exp_ack != 2'b00) begin
        checks++; if (gid_w1 !== exp_ack[1]) $display("FAIL b2b_gid c%0d: got %b want %b", c, gid_w1, exp_ack[1]); else passes++;
      end
    end
    m_req = 2'b00;
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    m_we = 2'b00; m_addr[25:0] = 26'h0000030; m_req = 2'b01;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 3) m_req = 2'b00;
    end
    m_we = 2'b10; m_wdata[63:32] = 32'h77778888; m_req = 2'b10;
    @(negedge clk);
    checks++; if (wr_w1 !== 1'b1) $display("FAIL rstmid_wr_before: got %b want 1", wr_w1); else passes++;
    #2 rst = 1'b1;
    #1;
    checks++; if (wr_w1 !== 1'b0) $display("FAIL rstmid_wr_async: got %b want 0", wr_w1); else passes++;
    checks++; if (din_w1 !== 32'h0) $display("FAIL rstmid_din_async: got %h want 0", din_w1); else passes++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (ack_w1 !== 2'b00) $display("FAIL rstmid_no_ack n%0d: got %b want 00", c, ack_w1); else passes++;
    end
    rst = 1'b0; m_we = 2'b00; m_req = 2'b11;
    @(negedge clk);
    checks++; if (gid_w1 !== 1'b0) $display("FAIL rstmid_first_gid: got %b want 0", gid_w1); else passes++;
    checks++; if ({rd_w1, wr_w1} !== 2'b10) $display("FAIL rstmid_first_strobe: got %b want 10", {rd_w1, wr_w1}); else passes++;
    @(negedge clk);
    @(negedge clk);
    checks++; if (ack_w1 !== 2'b01) $display("FAIL rstmid_first_ack: got %b want 01", ack_w1); else passes++;
    m_req = 2'b00;
  endtask

  task automatic test_wait_states();
    int n0, n3, f0, f3, a0, a3;
    logic [1:0] v0, v3;
    n0 = 0; n3 = 0; f0 = 0; f3 = 0; a0 = 0; a3 = 0; v0 = 2'b00; v3 = 2'b00;
    do_reset();
    m_we = 2'b00; m_addr[25:0] = 26'h0000010; mem_dout = 32'h12345678; m_req = 2'b01;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (rd_w0) begin n0++; if (f0 == 0) f0 = c; end
      if (rd_w3) begin n3++; if (f3 == 0) f3 = c; end
      if (ack_w0 != 2'b00 && a0 == 0) begin a0 = c; v0 = ack_w0; end
      if (ack_w3 != 2'b00 && a3 == 0) begin a3 = c; v3 = ack_w3; end
      if (c == 2) m_req = 2'b00;
    end
    checks++; if (n0 !== 1) $display("FAIL ws0_strobe_len: got %0d want 1", n0); else passes++;
    checks++; if (f0 !== 1) $display("FAIL ws0_strobe_start: got %0d want 1", f0); else passes++;
    checks++; if (a0 !== 2) $display("FAIL ws0_ack_cycle: got %0d want 2", a0); else passes++;
    checks++; if (v0 !== 2'b01) $display("FAIL ws0_ack_val: got %b want 01", v0); else passes++;
    checks++; if (rdata_w0 !== 32'h12345678) $display("FAIL ws0_rdata: got %h want 12345678", rdata_w0); else passes++;
    checks++; if (n3 !== 4) $display("FAIL ws3_strobe_len: got %0d want 4", n3); else passes++;
    checks++; if (f3 !== 1) $display("FAIL ws3_strobe_start: got %0d want 1", f3); else passes++;
    checks++; if (a3 !== 5) $display("FAIL ws3_ack_cycle: got %0d want 5", a3); else passes++;
    checks++; if (v3 !== 2'b01) $display("FAIL ws3_ack_val: got %b want 01", v3); else passes++;
    checks++; if (rdata_w3 !== 32'h12345678) $display("FAIL ws3_rdata: got %h want 12345678", rdata_w3); else passes++;
  endtask

  // Scenario sequence; read and write run back to back so the write can show M_RDATA is held.
  initial begin
    test_reset();
    test_read();
    test_write();
    test_drop_req();
    test_back_to_back();
    test_reset_mid_access();
    test_wait_states();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
